// File: rtl/mips_boot_controller.sv
// Boot sequencer for the pipelined MIPS core: program load, readback verify,
// timed run, then data-memory dump over a valid/ready stream.
module mips_boot_controller #(
  parameter logic [31:0] INSTR_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS  = 256,
  parameter int unsigned DUMP_CNT_W = 8
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  prog_valid_in,
  input  logic [31:0]           prog_word_in,
  input  logic                  prog_last_in,
  output logic                  prog_ready_out,
  input  logic [31:0]           run_cycles_in,
  input  logic [31:0]           dump_base_in,
  input  logic [DUMP_CNT_W-1:0] dump_count_in,
  output logic                  cpu_reset_out,
  output logic                  cpu_instrWrite_out,
  output logic [31:0]           cpu_instr_address_out,
  output logic [31:0]           cpu_instr_out,
  input  logic [31:0]           cpu_read_instr_in,
  output logic [31:0]           cpu_read_data_address_out,
  input  logic [31:0]           cpu_read_data_in,
  output logic                  dump_valid_out,
  output logic [31:0]           dump_data_out,
  input  logic                  dump_ready_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out
);

  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_RUN, S_DUMP, S_DONE} state_t;

  state_t                state, state_d;
  logic [CNT_W-1:0]      word_cnt, word_cnt_d, vidx, vidx_d;
  logic [31:0]           csum, csum_d, vsum, vsum_d;
  logic                  last_seen, last_seen_d;
  logic [31:0]           run_left, run_left_d;
  logic [31:0]           run_cycles_q, run_cycles_d;
  logic [31:0]           dump_base_q, dump_base_d;
  logic [DUMP_CNT_W-1:0] dump_count_q, dump_count_d, didx, didx_d;

  logic                  prog_ready_d, instr_write_d, dump_valid_d;
  logic                  cpu_reset_d, busy_d, done_d, error_d;
  logic [31:0]           instr_addr_d, instr_d, data_addr_d, dump_data_d;

  logic load_full, verify_last, verify_ok, run_end, dump_last;

  assign load_full   = (word_cnt == CNT_W'(MAX_WORDS));
  assign verify_last = (vidx == (word_cnt - CNT_W'(1)));
  assign verify_ok   = ((vsum ^ cpu_read_instr_in) == csum);
  assign run_end     = (run_left <= 32'd1);
  assign dump_last   = dump_valid_out && dump_ready_in &&
                       ((didx + DUMP_CNT_W'(1)) == dump_count_q);

  // State register
  always_ff @(posedge clock_in) begin
    if (reset_in) state <= S_IDLE;
    else          state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE, S_DONE: if (start_in) state_d = S_LOAD;
      S_LOAD: begin
        if (cpu_instrWrite_out) begin
          if (last_seen)      state_d = S_VERIFY;
          else if (load_full) state_d = S_DONE;
        end
      end
      S_VERIFY: if (verify_last) state_d = verify_ok ? S_RUN : S_DONE;
      S_RUN:    if (run_end) state_d = (dump_count_q == '0) ? S_DONE : S_DUMP;
      S_DUMP:   if (dump_last) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of datapath and registered outputs
  always_comb begin
    word_cnt_d    = word_cnt;
    vidx_d        = vidx;
    csum_d        = csum;
    vsum_d        = vsum;
    last_seen_d   = last_seen;
    run_left_d    = run_left;
    run_cycles_d  = run_cycles_q;
    dump_base_d   = dump_base_q;
    dump_count_d  = dump_count_q;
    didx_d        = didx;
    prog_ready_d  = prog_ready_out;
    instr_write_d = 1'b0;
    instr_addr_d  = cpu_instr_address_out;
    instr_d       = cpu_instr_out;
    data_addr_d   = cpu_read_data_address_out;
    dump_valid_d  = dump_valid_out;
    dump_data_d   = dump_data_out;
    cpu_reset_d   = cpu_reset_out;
    error_d       = error_out;
    busy_d        = (state_d == S_LOAD) || (state_d == S_VERIFY) ||
                    (state_d == S_RUN)  || (state_d == S_DUMP);
    done_d        = (state_d == S_DONE);

    unique case (state)
      S_IDLE, S_DONE: begin
        if (start_in) begin
          run_cycles_d = run_cycles_in;
          dump_base_d  = dump_base_in;
          dump_count_d = dump_count_in;
          word_cnt_d   = '0;
          csum_d       = '0;
          last_seen_d  = 1'b0;
          error_d      = 1'b0;
          prog_ready_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (cpu_instrWrite_out) begin
          // Write cycle just completed: decide whether to take another word
          if (last_seen) begin
            prog_ready_d = 1'b0;
            instr_addr_d = INSTR_BASE;
            vidx_d       = '0;
            vsum_d       = '0;
          end else if (load_full) begin
            prog_ready_d = 1'b0;
            error_d      = 1'b1;
          end else begin
            prog_ready_d = 1'b1;
          end
        end else if (prog_valid_in && prog_ready_out) begin
          prog_ready_d  = 1'b0;
          instr_write_d = 1'b1;
          instr_addr_d  = INSTR_BASE + (32'(word_cnt) << 2);
          instr_d       = prog_word_in;
          word_cnt_d    = word_cnt + CNT_W'(1);
          csum_d        = csum ^ prog_word_in;
          last_seen_d   = prog_last_in;
        end
      end
      S_VERIFY: begin
        vsum_d       = vsum ^ cpu_read_instr_in;
        vidx_d       = vidx + CNT_W'(1);
        instr_addr_d = INSTR_BASE + ((32'(vidx) + 32'd1) << 2);
        if (verify_last) begin
          if (verify_ok) begin
            run_left_d  = run_cycles_q;
            cpu_reset_d = (run_cycles_q == 32'd0);
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (run_left != 32'd0) run_left_d = run_left - 32'd1;
        if (run_end) begin
          cpu_reset_d = 1'b1;
          data_addr_d = dump_base_q;
          didx_d      = '0;
        end
      end
      S_DUMP: begin
        // Fetch phase captures the read, present phase holds until accepted
        if (!dump_valid_out) begin
          dump_data_d  = cpu_read_data_in;
          dump_valid_d = 1'b1;
        end else if (dump_ready_in) begin
          dump_valid_d = 1'b0;
          didx_d       = didx + DUMP_CNT_W'(1);
          data_addr_d  = cpu_read_data_address_out + 32'd4;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      word_cnt                  <= '0;
      vidx                      <= '0;
      csum                      <= '0;
      vsum                      <= '0;
      last_seen                 <= 1'b0;
      run_left                  <= '0;
      run_cycles_q              <= '0;
      dump_base_q               <= '0;
      dump_count_q              <= '0;
      didx                      <= '0;
      prog_ready_out            <= 1'b0;
      cpu_reset_out             <= 1'b1;
      cpu_instrWrite_out        <= 1'b0;
      cpu_instr_address_out     <= '0;
      cpu_instr_out             <= '0;
      cpu_read_data_address_out <= '0;
      dump_valid_out            <= 1'b0;
      dump_data_out             <= '0;
      busy_out                  <= 1'b0;
      done_out                  <= 1'b0;
      error_out                 <= 1'b0;
    end else begin
      word_cnt                  <= word_cnt_d;
      vidx                      <= vidx_d;
      csum                      <= csum_d;
      vsum                      <= vsum_d;
      last_seen                 <= last_seen_d;
      run_left                  <= run_left_d;
      run_cycles_q              <= run_cycles_d;
      dump_base_q               <= dump_base_d;
      dump_count_q              <= dump_count_d;
      didx                      <= didx_d;
      prog_ready_out            <= prog_ready_d;
      cpu_reset_out             <= cpu_reset_d;
      cpu_instrWrite_out        <= instr_write_d;
      cpu_instr_address_out     <= instr_addr_d;
      cpu_instr_out             <= instr_d;
      cpu_read_data_address_out <= data_addr_d;
      dump_valid_out            <= dump_valid_d;
      dump_data_out             <= dump_data_d;
      busy_out                  <= busy_d;
      done_out                  <= done_d;
      error_out                 <= error_d;
    end
  end

endmodule

// File: tb/tb_mips_boot_controller.sv
// Scoreboard bench for mips_boot_controller: a job-level reference model queues
// expected writes, run pulses, dump words and final status; a monitor checks them.
module tb_mips_boot_controller;

  localparam int unsigned MAXW = 4;
  localparam int unsigned DCW  = 8;

  logic           clock_in, reset_in, start_in;
  logic           prog_valid_in, prog_last_in, prog_ready_out;
  logic [31:0]    prog_word_in, run_cycles_in, dump_base_in;
  logic [DCW-1:0] dump_count_in;
  logic           cpu_reset_out, cpu_instrWrite_out;
  logic [31:0]    cpu_instr_address_out, cpu_instr_out, cpu_read_instr_in;
  logic [31:0]    cpu_read_data_address_out, cpu_read_data_in;
  logic           dump_valid_out, dump_ready_in;
  logic [31:0]    dump_data_out;
  logic           busy_out, done_out, error_out;

  mips_boot_controller #(.INSTR_BASE(32'h0), .MAX_WORDS(MAXW), .DUMP_CNT_W(DCW)) dut (
    .clock_in(clock_in), .reset_in(reset_in), .start_in(start_in),
    .prog_valid_in(prog_valid_in), .prog_word_in(prog_word_in),
    .prog_last_in(prog_last_in), .prog_ready_out(prog_ready_out),
    .run_cycles_in(run_cycles_in), .dump_base_in(dump_base_in),
    .dump_count_in(dump_count_in), .cpu_reset_out(cpu_reset_out),
    .cpu_instrWrite_out(cpu_instrWrite_out),
    .cpu_instr_address_out(cpu_instr_address_out), .cpu_instr_out(cpu_instr_out),
    .cpu_read_instr_in(cpu_read_instr_in),
    .cpu_read_data_address_out(cpu_read_data_address_out),
    .cpu_read_data_in(cpu_read_data_in), .dump_valid_out(dump_valid_out),
    .dump_data_out(dump_data_out), .dump_ready_in(dump_ready_in),
    .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } xact_t;

  xact_t       exp_wr[$];
  xact_t       exp_dump[$];
  int          exp_run[$];
  bit          exp_err[$];
  logic [31:0] prog_q[$];
  int          rdy_pat[$];
  bit          rdy_random;
  bit          inj_fault;
  int          checks, failures;
  logic [31:0] imem [0:7];

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Synthetic data memory contents as a function of byte address
  function automatic logic [31:0] dfun(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Core memory stand-ins: instruction memory with optional readback fault
  always @(posedge clock_in)
    if (cpu_instrWrite_out) imem[cpu_instr_address_out[4:2]] <= cpu_instr_out;
  always_comb
    cpu_read_instr_in = imem[cpu_instr_address_out[4:2]] ^
                        ((inj_fault && cpu_instr_address_out == 32'd4) ? 32'd1 : 32'd0);
  always_comb cpu_read_data_in = dfun(cpu_read_data_address_out);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event expected=no event queued", name);
  endtask

  // Ready driver: pattern entries are consumed only on cycles with valid high
  initial begin
    dump_ready_in = 1'b0;
    forever begin
      @(posedge clock_in); #1;
      if (dump_valid_out && rdy_pat.size() > 0) dump_ready_in = rdy_pat.pop_front() != 0;
      else dump_ready_in = rdy_random ? 1'($urandom % 2) : 1'b1;
    end
  end

  // Monitor
  bit          prev_valid, prev_ready, prev_done;
  logic [31:0] prev_data;
  int          low_cnt;
  xact_t       mon_e;
  initial begin prev_valid = 0; prev_ready = 0; prev_done = 0; prev_data = 0; low_cnt = 0; end

  always @(negedge clock_in) begin
    if (cpu_instrWrite_out) begin
      if (exp_wr.size() == 0) unexpected("instr_write");
      else begin
        mon_e = exp_wr.pop_front();
        chk("wr_addr", cpu_instr_address_out, mon_e.addr);
        chk("wr_data", cpu_instr_out, mon_e.data);
      end
    end
    if (prev_valid && !prev_ready) begin
      chk("dump_hold_valid", 32'(dump_valid_out), 32'd1);
      chk("dump_hold_data", dump_data_out, prev_data);
    end
    if (dump_valid_out && dump_ready_in) begin
      if (exp_dump.size() == 0) unexpected("dump_xfer");
      else begin
        mon_e = exp_dump.pop_front();
        chk("dump_addr", cpu_read_data_address_out, mon_e.addr);
        chk("dump_data", dump_data_out, mon_e.data);
      end
    end
    if (!cpu_reset_out) low_cnt++;
    else if (low_cnt > 0) begin
      if (exp_run.size() == 0) unexpected("cpu_release");
      else chk("run_low_cycles", 32'(low_cnt), 32'(exp_run.pop_front()));
      low_cnt = 0;
    end
    if (done_out && !prev_done) begin
      if (exp_err.size() == 0) unexpected("done_rise");
      else chk("final_error", 32'(error_out), 32'(exp_err.pop_front()));
    end
    prev_valid = dump_valid_out;
    prev_ready = dump_ready_in;
    prev_data  = dump_data_out;
    prev_done  = done_out;
  end

  task automatic tick();
    @(posedge clock_in); #1;
  endtask

  task automatic start_job(input logic [31:0] rc, input logic [31:0] base, input int cnt);
    run_cycles_in = rc;
    dump_base_in  = base;
    dump_count_in = DCW'(cnt);
    start_in      = 1'b1;
    tick();
    start_in      = 1'b0;
  endtask

  task automatic feed(input int n_wr, input bit has_last, input int n);
    bit hs;
    for (int i = 0; i < n_wr; i++) begin
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
      prog_valid_in = 1'b1;
      prog_word_in  = prog_q[i];
      prog_last_in  = has_last && (i == n - 1);
      hs = 1'b0;
      for (int c = 0; c < 50 && !hs; c++) begin
        @(negedge clock_in);
        hs = prog_ready_out;
        tick();
      end
      prog_valid_in = 1'b0;
      prog_last_in  = 1'b0;
      if (!hs) begin
        unexpected("prog_ready_timeout");
        break;
      end
    end
  endtask

  task automatic flush_check();
    repeat (3) tick();
    chk("left_writes", 32'(exp_wr.size()), 32'd0);
    chk("left_dump", 32'(exp_dump.size()), 32'd0);
    chk("left_run", 32'(exp_run.size()), 32'd0);
    chk("left_status", 32'(exp_err.size()), 32'd0);
    exp_wr.delete(); exp_dump.delete(); exp_run.delete(); exp_err.delete();
    rdy_pat.delete();
  endtask

  // One full job: reference model fills the queues, then stimulus drives it
  task automatic run_job(input bit has_last, input logic [31:0] rc,
                         input logic [31:0] base, input int cnt, input bit fault);
    int  n    = prog_q.size();
    int  n_wr = has_last ? n : int'(MAXW);
    bit  err  = !has_last || (fault && n >= 2);
    int  c;
    for (int i = 0; i < n_wr; i++) exp_wr.push_back('{32'(4 * i), prog_q[i]});
    if (!err) begin
      if (rc != 0) exp_run.push_back(int'(rc));
      for (int i = 0; i < cnt; i++) exp_dump.push_back('{base + 32'(4 * i), dfun(base + 32'(4 * i))});
    end
    exp_err.push_back(err);
    inj_fault = fault;
    start_job(rc, base, cnt);
    feed(n_wr, has_last, n);
    for (c = 0; c < 2000 && !done_out; c++) tick();
    if (!done_out) unexpected("done_timeout");
    chk("busy_in_done", 32'(busy_out), 32'd0);
    if (!has_last) chk("ovf_no_verify_addr", cpu_instr_address_out, 32'(4 * (MAXW - 1)));
    flush_check();
    inj_fault = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; inj_fault = 0; rdy_random = 0;
    reset_in = 1'b1; start_in = 1'b0; prog_valid_in = 1'b0; prog_last_in = 1'b0;
    prog_word_in = '0; run_cycles_in = '0; dump_base_in = '0; dump_count_in = '0;
    repeat (3) tick();
    reset_in = 1'b0;
    tick();
    chk("rst_cpu_reset", 32'(cpu_reset_out), 32'd1);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_error", 32'(error_out), 32'd0);
    chk("rst_prog_ready", 32'(prog_ready_out), 32'd0);
    chk("rst_dump_valid", 32'(dump_valid_out), 32'd0);
    chk("rst_instr_addr", cpu_instr_address_out, 32'd0);

    prog_q = '{32'h2008_0005, 32'h2009_0003, 32'hAC08_0000};
    run_job(1'b1, 32'd0, 32'h0, 0, 1'b0);
    chk("basic_done", 32'(done_out), 32'd1);
    run_job(1'b1, 32'd5, 32'h40, 2, 1'b1);
    prog_q = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    run_job(1'b0, 32'd6, 32'h0, 2, 1'b0);
    prog_q = '{32'h2008_0005, 32'h2009_0003, 32'hAC08_0000};
    run_job(1'b1, 32'd10, 32'h0, 0, 1'b0);
    rdy_pat = '{1, 0, 0, 1, 1};
    run_job(1'b1, 32'd3, 32'h10, 3, 1'b0);
    prog_q = '{32'hDEAD_BEEF};
    run_job(1'b1, 32'd1, 32'hFFFF_FFF8, 4, 1'b0);
    prog_q = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0004, 32'h0000_0008};
    run_job(1'b1, 32'd2, 32'h100, 1, 1'b0);

    // Reset during the fourth run cycle aborts the job
    prog_q = '{32'h2008_0005, 32'h2009_0003, 32'hAC08_0000};
    for (int i = 0; i < 3; i++) exp_wr.push_back('{32'(4 * i), prog_q[i]});
    exp_run.push_back(4);
    start_job(32'd20, 32'h20, 2);
    feed(3, 1'b1, 3);
    for (int c = 0; c < 200 && cpu_reset_out; c++) tick();
    if (cpu_reset_out) unexpected("run_start_timeout");
    repeat (3) tick();
    reset_in = 1'b1;
    tick();
    chk("abort_cpu_reset", 32'(cpu_reset_out), 32'd1);
    chk("abort_busy", 32'(busy_out), 32'd0);
    chk("abort_done", 32'(done_out), 32'd0);
    chk("abort_error", 32'(error_out), 32'd0);
    chk("abort_prog_ready", 32'(prog_ready_out), 32'd0);
    chk("abort_write", 32'(cpu_instrWrite_out), 32'd0);
    chk("abort_instr_addr", cpu_instr_address_out, 32'd0);
    chk("abort_instr", cpu_instr_out, 32'd0);
    chk("abort_data_addr", cpu_read_data_address_out, 32'd0);
    chk("abort_dump_valid", 32'(dump_valid_out), 32'd0);
    chk("abort_dump_data", dump_data_out, 32'd0);
    reset_in = 1'b0;
    flush_check();
    run_job(1'b1, 32'd4, 32'h30, 2, 1'b0);

    // Randomized jobs with random consumer backpressure
    rdy_random = 1'b1;
    for (int j = 0; j < 25; j++) begin
      bit ovf   = ($urandom % 6) == 0;
      int n     = ovf ? int'(MAXW) : int'($urandom_range(1, MAXW));
      bit fault = (n >= 2) && (($urandom % 5) == 0);
      logic [31:0] base = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      prog_q.delete();
      for (int i = 0; i < n; i++) prog_q.push_back($urandom);
      run_job(!ovf, 32'($urandom_range(0, 12)), base, int'($urandom_range(0, 5)), fault);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
